// File: rtl/tick_seq_pkg.sv
// Shared definitions for the tick pattern sequencer: FSM state encoding
// and default widths for the pattern and repeat count.
package tick_seq_pkg;

  localparam int DEF_PATTERN_W = 8;
  localparam int DEF_REPEAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/tick_edge_sync.sv
// Turns the divided slow_clock into a one-cycle tick on each rising edge.
// Build option TICK_SEQ_SYNC_EN: when defined, slow_clock first passes a
// 2-flop synchroniser (asynchronous source); when undefined, slow_clock is
// assumed to come from the clock_in domain and is edge-detected directly.
// A level that is already high when reset is released is not treated as an
// edge: a low level must be seen before the first tick can fire.
module tick_edge_sync
  import tick_seq_pkg::*;
(
  input  logic clock_in,
  input  logic reset,
  input  logic slow_clock,
  output logic tick
);

  logic level;
  logic level_q;
  logic seen_low;

`ifdef TICK_SEQ_SYNC_EN
  logic sync_1;
  logic sync_2;

  // two-stage synchroniser for the asynchronous slow_clock
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= slow_clock;
      sync_2 <= sync_1;
    end
  end

  assign level = sync_2;
`else
  assign level = slow_clock;
`endif

  // previous level for edge detect, plus arming after the first low level
  always_ff @(posedge clock_in) begin
    if (reset) begin
      level_q  <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      level_q <= level;
      if (!level) begin
        seen_low <= 1'b1;
      end
    end
  end

  assign tick = level & ~level_q & seen_low;

endmodule

// File: rtl/tick_pattern_sequencer.sv
// Shows a latched bit pattern on led, one bit per slow_clock period, LSB
// first, for repeat_count+1 passes, then pulses done.
// Build option TICK_SEQ_SYNC_EN selects the synchronised tick path inside
// tick_edge_sync (see that file).
//
// state | meaning
// IDLE  | waiting for start; led=0, busy=0
// ARM   | sequence accepted, waiting for first tick to show bit 0
// RUN   | showing one pattern bit per tick until the final pass ends
module tick_pattern_sequencer
  import tick_seq_pkg::*;
#(
  parameter int PATTERN_W = DEF_PATTERN_W,
  parameter int REPEAT_W  = DEF_REPEAT_W
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 slow_clock,
  input  logic                 start,
  input  logic                 stop,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [REPEAT_W-1:0]  repeat_count,
  output logic                 led,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W  = $clog2(PATTERN_W);
  localparam int PASS_W = REPEAT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_W - 1);

  seq_state_t           state;
  logic [PATTERN_W-1:0] pattern_q;
  logic [REPEAT_W-1:0]  repeat_q;
  logic [IDX_W-1:0]     bit_idx;
  logic [PASS_W-1:0]    pass_cnt;
  logic [PASS_W-1:0]    pass_target;
  logic                 tick;

  tick_edge_sync u_tick_edge_sync (
    .clock_in   (clock_in),
    .reset      (reset),
    .slow_clock (slow_clock),
    .tick       (tick)
  );

  // one extra bit keeps repeat_count all-ones from wrapping the target
  assign pass_target = PASS_W'(repeat_q) + PASS_W'(1);

  // sequencer FSM with registered led/busy/done
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= IDLE;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_idx   <= '0;
      pass_cnt  <= '0;
      pattern_q <= '0;
      repeat_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          led  <= 1'b0;
          busy <= 1'b0;
          if (start && !stop) begin
            pattern_q <= pattern;
            repeat_q  <= repeat_count;
            bit_idx   <= '0;
            pass_cnt  <= '0;
            busy      <= 1'b1;
            state     <= ARM;
          end
        end
        ARM: begin
          if (stop) begin
            led   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            led     <= pattern_q[0];
            bit_idx <= IDX_W'(1);
            state   <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            led   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            if (bit_idx == '0 && pass_cnt == pass_target) begin
              led   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              led <= pattern_q[bit_idx];
              if (bit_idx == LAST_IDX) begin
                bit_idx  <= '0;
                pass_cnt <= pass_cnt + PASS_W'(1);
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end
        end
        default: begin
          led   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_pattern_sequencer.sv
// Scoreboard bench for tick_pattern_sequencer. The stimulus pushes the
// expected {busy, led, done} seen after each slow_clock tick; a monitor
// samples the outputs once per slow_clock rise and pops/compares.
module tb_tick_pattern_sequencer;

`ifdef TICK_SEQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic busy;
    logic led;
    logic done;
  } obs_t;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clock = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] repeat_count = 4'h0;
  logic       led;
  logic       busy;
  logic       done;

  obs_t exp_q[$];
  int   tests = 0;
  int   failed = 0;
  int   tick_num = 0;
  int   done_seen = 0;
  int   exp_dones = 0;

  tick_pattern_sequencer dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .slow_clock   (slow_clock),
    .start        (start),
    .stop         (stop),
    .pattern      (pattern),
    .repeat_count (repeat_count),
    .led          (led),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock_in = ~clock_in;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // per-tick monitor
  initial begin : monitor
    obs_t e;
    obs_t got;
    forever begin
      @(posedge slow_clock);
      repeat (LAT) @(posedge clock_in);
      @(negedge clock_in);
      tick_num++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {busy, led, done};
        tests++;
        if (got !== e) begin
          failed++;
          $display("FAIL tick_%0d {busy,led,done}: got %b required %b", tick_num, got, e);
        end
      end
    end
  end

  // done must be a single-cycle pulse
  initial begin : done_mon
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clock_in);
      if (done === 1'b1) begin
        done_seen++;
        tests++;
        if (prev_done !== 1'b0) begin
          failed++;
          $display("FAIL done_single_cycle: got done high twice, required one cycle");
        end
      end
      prev_done = done;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic l, input logic d);
    obs_t o;
    o = {b, l, d};
    exp_q.push_back(o);
  endtask

  task automatic push_run(input logic [7:0] pat, input int rep);
    for (int p = 0; p <= rep; p++)
      for (int i = 0; i < 8; i++)
        push(1'b1, pat[i], 1'b0);
    push(1'b0, 1'b0, 1'b1);
    exp_dones++;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] r);
    pattern      = p;
    repeat_count = r;
    start        = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // one slow_clock period: 2 cycles high, 2 low; optional stop on the tick edge
  task automatic period(input bit stop_at_tick);
    for (int i = 1; i <= 4; i++) begin
      slow_clock = (i <= 2);
      stop       = stop_at_tick && (i == LAT);
      cyc(1);
    end
    stop = 1'b0;
  endtask

  task automatic periods(input int n);
    for (int k = 0; k < n; k++) period(1'b0);
  endtask

  initial begin : stimulus
    int  lat_meas;
    bit  found;

    cyc(3);
    reset = 1'b0;
    @(negedge clock_in);
    check("reset_state", {29'd0, busy, led, done}, 32'd0);
    cyc(2);

    // pattern 1010_0110, single pass
    push_run(8'b1010_0110, 0);
    push(1'b0, 1'b0, 1'b0);
    do_start(8'b1010_0110, 4'd0);
    periods(10);

    // first-update latency after slow_clock is first sampled high
    push(1'b1, 1'b1, 1'b0);
    do_start(8'h03, 4'd0);
    slow_clock = 1'b1;
    lat_meas = 0;
    found = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (!found && led === 1'b1) begin
        found    = 1'b1;
        lat_meas = k;
      end
      slow_clock = (k < 2);
    end
    check("first_led_latency", lat_meas, LAT);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    @(negedge clock_in);
    check("stop_from_run", {30'd0, busy, led}, 32'd0);

    // three passes of all-ones, then done
    push_run(8'hFF, 2);
    do_start(8'hFF, 4'd2);
    periods(25);

    // stop at the 3rd tick in RUN
    push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    do_start(8'hFF, 4'd0);
    periods(3);
    period(1'b1);
    period(1'b0);

    // stop on the final completion tick: no done
    for (int i = 0; i < 8; i++) push(1'b1, (i == 0 || i == 7), 1'b0);
    push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    do_start(8'h81, 4'd0);
    periods(8);
    period(1'b1);
    period(1'b0);

    // start re-pulsed mid-run is ignored
    push_run(8'b1100_1010, 0);
    push(1'b0, 1'b0, 1'b0);
    do_start(8'b1100_1010, 4'd0);
    periods(3);
    do_start(8'h00, 4'hF);
    periods(7);

    // start and stop together in IDLE
    push(1'b0, 1'b0, 1'b0);
    pattern = 8'hFF;
    start   = 1'b1;
    stop    = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clock_in);
    check("start_with_stop_idle", {31'd0, busy}, 32'd0);
    period(1'b0);

    // repeat_count all-ones: 16 passes
    push_run(8'h01, 15);
    do_start(8'h01, 4'hF);
    periods(129);

    // reset mid-run with slow_clock high
    push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    do_start(8'h05, 4'd0);
    periods(2);
    slow_clock = 1'b1;
    reset      = 1'b1;
    cyc(2);
    @(negedge clock_in);
    check("reset_mid_run", {29'd0, busy, led, done}, 32'd0);
    reset = 1'b0;
    do_start(8'h05, 4'd0);
    cyc(3);
    @(negedge clock_in);
    check("no_tick_high_at_release", {30'd0, busy, led}, 32'd2);
    push_run(8'h05, 0);
    slow_clock = 1'b0;
    cyc(2);
    periods(9);

    cyc(6);
    check("queue_drained", exp_q.size(), 0);
    check("done_pulse_count", done_seen, exp_dones);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
